seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_pkg.sv | 28 ++
 rtl/seq_shifter_shift_step.sv | 40 ++++
 rtl/seq_shifter.sv | 132 +++++++++++++
 tb/tb_seq_shifter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg -- shared definitions for the sequential shifter.
//   Op encodings for the operation select input and the FSM state
//   encoding, plus small helpers to classify an op code.
package seq_shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Logical/arithmetic shifts saturate their count at WIDTH.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Rotates take their count modulo WIDTH.
    function automatic logic is_rot(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step -- combinational single step of the sequential shifter.
//   data    : working value
//   op      : operation code (seq_shifter_pkg encodings)
//   s       : bits to shift this step, 0..WIDTH
//   sign    : sign bit of the originally captured operand (SRA fill)
//   shifted : data shifted/rotated by s
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S_W   = 6
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic [S_W-1:0]   s,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);

    logic [S_W-1:0]   s_inv;
    logic [WIDTH-1:0] hi_mask;

    always_comb begin
        // s_inv is the complementary rotate amount; when s is 0 it equals
        // WIDTH and the wrapped-in term shifts out to zero.
        s_inv   = S_W'(WIDTH) - s;
        // Ones in the top s positions, used to fill for SRA.
        hi_mask = ~({WIDTH{1'b1}} >> s);
        shifted = data;
        case (op)
            OP_SLL:  shifted = data << s;
            OP_SRL:  shifted = data >> s;
            OP_SRA:  shifted = sign ? ((data >> s) | hi_mask) : (data >> s);
            OP_ROL:  shifted = (data << s) | (data >> s_inv);
            OP_ROR:  shifted = (data >> s) | (data << s_inv);
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter -- multi-cycle barrel-free shifter, up to STEP bits per clock.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   start            : request, accepted in IDLE or DONE
//   op, a, amount    : operation, operand and shift count, captured on accept
//   busy             : high while shifting (RUN)
//   done             : one-cycle pulse when result is updated (DONE)
//   result           : registered result, held until the next completion
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [31:0]      WIDTH_U = 32'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0]      amt32;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] step_s;
    logic [CNT_W-1:0] cnt_left;
    logic [WIDTH-1:0] step_out;

    shift_step #(
        .WIDTH (WIDTH),
        .S_W   (CNT_W)
    ) u_step (
        .data    (work_q),
        .op      (op_q),
        .s       (step_s),
        .sign    (sign_q),
        .shifted (step_out)
    );

    always_comb begin
        amt32 = 32'(amount);
        n_eff = '0;
        if (is_shift(op))
            n_eff = (amt32 >= WIDTH_U) ? CNT_W'(WIDTH) : CNT_W'(amt32);
        else if (is_rot(op))
            n_eff = CNT_W'(amt32 % WIDTH_U);

        step_s   = (cnt_q > STEP_C) ? STEP_C : cnt_q;
        cnt_left = cnt_q - step_s;

        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d   = op;
                    sign_d = a[WIDTH-1];
                    work_d = a;
                    cnt_d  = n_eff;
                    if (n_eff == '0) begin
                        // Zero count (including reserved ops) completes at once.
                        result_d = a;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d = step_out;
                cnt_d  = cnt_left;
                if (cnt_left == '0) begin
                    result_d = step_out;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    localparam logic [2:0] SLL = 3'b000, SRL = 3'b001, SRA = 3'b010,
                           ROL = 3'b011, ROR = 3'b100, RSV = 3'b101;

    logic        clock = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic [2:0]  op;
    logic [31:0] a;
    logic [5:0]  amount;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    seq_shifter #(.WIDTH(32), .AMT_W(6), .STEP(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .op(op), .a(a),
        .amount(amount), .busy(busy1), .done(done1), .result(result1));

    seq_shifter #(.WIDTH(32), .AMT_W(6), .STEP(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .op(op), .a(a),
        .amount(amount), .busy(busy4), .done(done4), .result(result4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model, written directly from the operation definitions.
    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] av,
                                              input int amt);
        logic [63:0] t;
        int r;
        r = amt % 32;
        case (o)
            SLL: return (amt >= 32) ? 32'h0 : av << amt;
            SRL: return (amt >= 32) ? 32'h0 : av >> amt;
            SRA: return (amt >= 32) ? {32{av[31]}} : 32'($signed(av) >>> amt);
            ROL: begin t = {av, av} << r; return t[63:32]; end
            ROR: begin t = {av, av} >> r; return t[31:0]; end
            default: return av;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input int amt, input int step);
        int n;
        if (o == SLL || o == SRL || o == SRA) n = (amt >= 32) ? 32 : amt;
        else if (o == ROL || o == ROR)        n = amt % 32;
        else                                  n = 0;
        return (n + step - 1) / step;
    endfunction

    // Drive a request at the current (negedge) time; returns 1 ns after the
    // accepting edge with inputs scrambled to show they are not re-sampled.
    task automatic issue(input bit use4, input logic [2:0] o, input logic [31:0] av,
                         input logic [5:0] amt);
        exp_t e;
        e.res = model_res(o, av, int'(amt));
        e.lat = model_lat(o, int'(amt), use4 ? 4 : 1);
        sb.push_back(e);
        op = o; a = av; amount = amt;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        op = 3'($urandom); a = $urandom; amount = 6'($urandom);
    endtask

    // Watch for done; k counts negedges after the accepting edge (edge 0).
    task automatic wait_done(input bit use4, input int k0);
        logic d, b;
        logic [31:0] r;
        exp_t e;
        for (int k = k0; k < k0 + 100; k++) begin
            @(negedge clock);
            d = use4 ? done4 : done1;
            b = use4 ? busy4 : busy1;
            r = use4 ? result4 : result1;
            chk("busy_done_exclusive", {31'b0, b & d}, 32'h0);
            if (d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("result", r, e.res);
                    chk("latency", 32'(k), 32'(e.lat));
                end
                return;
            end
        end
        chk("done_timeout", 32'h1, 32'h0);
    endtask

    task automatic run(input bit use4, input logic [2:0] o, input logic [31:0] av,
                       input logic [5:0] amt);
        issue(use4, o, av, amt);
        wait_done(use4, 0);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        op = SLL; a = '0; amount = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_busy", {31'b0, busy1}, 32'h0);
        chk("reset_done", {31'b0, done1}, 32'h0);
        chk("reset_result", result1, 32'h0);
        chk("reset_result4", result4, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run(0, SLL, 32'd3072, 6'd3);              // 24576, done after edge 3
        run(0, SRL, 32'd3072, 6'd3);              // 384
        run(0, SRA, 32'h8000_0000, 6'd4);         // F8000000
        run(0, ROR, 32'h0000_0001, 6'd1);         // 80000000
        run(0, ROL, 32'h0000_0001, 6'd33);        // 2, done after edge 1
        run(0, SLL, 32'hDEAD_BEEF, 6'd40);        // 0
        run(0, SRL, 32'hDEAD_BEEF, 6'd32);        // 0
        run(0, SRA, 32'h9000_0000, 6'd63);        // all ones
        run(0, SRA, 32'h7000_0000, 6'd40);        // 0
        run(0, SLL, 32'h0000_1234, 6'd0);         // a, done after edge 0
        run(0, RSV, 32'hCAFE_F00D, 6'd5);         // reserved: a, immediate
        run(0, ROL, 32'h8000_0001, 6'd32);        // mod -> 0, immediate
        run(1, SRL, 32'hFFFF_FFFF, 6'd10);        // 003FFFFF, done after edge 3
        run(1, ROL, 32'h8000_0001, 6'd7);
        run(1, SRA, 32'h8765_4321, 6'd13);
        run(1, ROR, 32'h1234_5678, 6'd31);

        // Back-to-back: new start on the DONE cycle, including a zero-count one.
        issue(0, ROL, 32'hA5A5_0F0F, 6'd5);
        wait_done(0, 0);
        issue(0, SRA, 32'hF000_0000, 6'd2);
        wait_done(0, 0);
        issue(0, SRL, 32'h0000_00FF, 6'd0);
        wait_done(0, 0);
        @(negedge clock);

        // Start while busy is ignored.
        issue(0, SLL, 32'd3072, 6'd3);
        @(negedge clock);
        chk("busy_in_run", {31'b0, busy1}, 32'h1);
        op = SRL; a = 32'hFFFF_FFFF; amount = 6'd1; start1 = 1'b1;
        @(posedge clock);
        #1 start1 = 1'b0;
        wait_done(0, 1);
        @(negedge clock);

        // Reset mid-operation (result currently nonzero).
        issue(0, SLL, 32'd3072, 6'd3);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midreset_busy", {31'b0, busy1}, 32'h0);
        chk("midreset_done", {31'b0, done1}, 32'h0);
        chk("midreset_result", result1, 32'h0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("no_done_after_reset", {31'b0, done1}, 32'h0);
        end

        // First start after reset is accepted.
        run(0, ROR, 32'h0000_0003, 6'd2);
        run(1, SLL, 32'h0000_0001, 6'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
